// File: rtl/timed_relay_chain.sv
// Series chain of timed relays: each armature follows its coil only after
// a sustained drive, and the contacts form an AND chain fed from batt.
module timed_relay_chain #(
    parameter int                STAGES   = 4,
    parameter int                PULL_IN  = 3,
    parameter int                DROP_OUT = 2,
    parameter logic [STAGES-1:0] NC_MASK  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              batt,
    input  logic [STAGES-1:0] switch,
    output logic [STAGES-1:0] armature,
    output logic [STAGES-1:0] contact,
    output logic              out,
    output logic              settled
);

    localparam int TMAX = (PULL_IN > DROP_OUT) ? PULL_IN : DROP_OUT;
    localparam int CW   = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] PI_LAST = CW'(PULL_IN - 1);
    localparam logic [CW-1:0] DO_LAST = CW'(DROP_OUT - 1);

    generate
        if (STAGES < 1 || PULL_IN < 1 || DROP_OUT < 1) begin : g_bad_params
            $error("timed_relay_chain: STAGES, PULL_IN, DROP_OUT must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0] a;
    logic [STAGES-1:0] busy;
    logic [STAGES-1:0] closed;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            logic [CW-1:0] cnt;
            logic [CW-1:0] last;

            assign last    = switch[i] ? PI_LAST : DO_LAST;
            assign busy[i] = |cnt;

            // Count consecutive mismatching edges; flip armature on the last one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a[i] <= 1'b0;
                    cnt  <= '0;
                end else if (switch[i] == a[i]) begin
                    cnt  <= '0;
                end else if (cnt == last) begin
                    a[i] <= ~a[i];
                    cnt  <= '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign closed = a ^ NC_MASK;

    generate
        for (i = 0; i < STAGES; i++) begin : g_contact
            if (i == 0) begin : g_first
                assign contact[i] = batt & closed[i];
            end else begin : g_next
                assign contact[i] = contact[i-1] & closed[i];
            end
        end
    endgenerate

    assign armature = a;
    assign out      = contact[STAGES-1];
    assign settled  = ~|busy;

endmodule

// File: tb/tb_timed_relay_chain.sv
// Directed bench for timed_relay_chain: default chain, a normally-closed
// variant and a single-edge timing variant.
module tb_timed_relay_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       batt = 1'b1;
    logic [3:0] sw = 4'b0000;
    logic [3:0] arm, con;
    logic       out, settled;

    logic [3:0] sw_nc = 4'b0000;
    logic [3:0] arm_nc, con_nc;
    logic       out_nc, settled_nc;

    logic [1:0] sw_f = 2'b00;
    logic [1:0] arm_f, con_f;
    logic       out_f, settled_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timed_relay_chain dut (
        .clk(clk), .rst(rst), .batt(batt), .switch(sw),
        .armature(arm), .contact(con), .out(out), .settled(settled)
    );

    timed_relay_chain #(.NC_MASK(4'b0010)) dut_nc (
        .clk(clk), .rst(rst), .batt(batt), .switch(sw_nc),
        .armature(arm_nc), .contact(con_nc), .out(out_nc),
        .settled(settled_nc)
    );

    timed_relay_chain #(.STAGES(2), .PULL_IN(1), .DROP_OUT(1)) dut_f (
        .clk(clk), .rst(rst), .batt(batt), .switch(sw_f),
        .armature(arm_f), .contact(con_f), .out(out_f),
        .settled(settled_f)
    );

    typedef struct {
        logic       rst;
        logic       batt;
        logic [3:0] sw;
        logic [3:0] arm;
        logic [3:0] con;
        logic       out;
        logic       settled;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst batt sw   arm    con    out settled
        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'b1101, 4'b1111, 4'b1111, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'b1101, 4'b1101, 4'b0001, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 4'b1111, 4'b1101, 4'b0001, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 4'b1111, 4'b1101, 4'b0001, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};

        for (int i = 0; i < 19; i++) begin
            rst  = vecs[i].rst;
            batt = vecs[i].batt;
            sw   = vecs[i].sw;
            edge1();
            chk($sformatf("v%0d armature", i), 8'(arm), 8'(vecs[i].arm));
            chk($sformatf("v%0d contact", i), 8'(con), 8'(vecs[i].con));
            chk($sformatf("v%0d out", i), 8'(out), 8'(vecs[i].out));
            chk($sformatf("v%0d settled", i), 8'(settled), 8'(vecs[i].settled));
        end

        // batt acts on the contacts combinationally, never on state
        batt = 1'b0;
        #1;
        chk("batt0 contact", 8'(con), 8'(4'b0000));
        chk("batt0 out", 8'(out), 8'(1'b0));
        chk("batt0 armature", 8'(arm), 8'(4'b1111));
        batt = 1'b1;
        #1;
        chk("batt1 contact", 8'(con), 8'(4'b1111));
        chk("batt1 out", 8'(out), 8'(1'b1));

        // reset wins over a stage that is mid drop-out
        sw = 4'b0000;
        edge1();
        chk("midtransit armature", 8'(arm), 8'(4'b1111));
        chk("midtransit settled", 8'(settled), 8'(1'b0));
        rst = 1'b1;
        edge1();
        chk("rst armature", 8'(arm), 8'(4'b0000));
        chk("rst settled", 8'(settled), 8'(1'b1));
        chk("rst contact", 8'(con), 8'(4'b0000));

        // normally-closed stage 1 inverts switch[1]
        chk("nc rst contact", 8'(con_nc), 8'(4'b0000));
        chk("nc rst armature", 8'(arm_nc), 8'(4'b0000));
        rst   = 1'b0;
        sw_nc = 4'b1101;
        edge1();
        edge1();
        chk("nc edge2 armature", 8'(arm_nc), 8'(4'b0000));
        edge1();
        chk("nc edge3 armature", 8'(arm_nc), 8'(4'b1101));
        chk("nc edge3 contact", 8'(con_nc), 8'(4'b1111));
        chk("nc edge3 out", 8'(out_nc), 8'(1'b1));

        // single-edge thresholds flip on the first mismatching edge
        sw_f = 2'b11;
        edge1();
        chk("fast pull armature", 8'(arm_f), 8'(2'b11));
        chk("fast pull settled", 8'(settled_f), 8'(1'b1));
        chk("fast pull out", 8'(out_f), 8'(1'b1));
        sw_f = 2'b00;
        edge1();
        chk("fast drop armature", 8'(arm_f), 8'(2'b00));
        chk("fast drop contact", 8'(con_f), 8'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
